mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter that shares the node's single-port data memory among up to NREQ requesters, e.g. reward, learning and packet-handling engines.
- Each requester presents an address, write enable and write data. The arbiter grants one requester at a time and muxes that requester onto the memory port.
- The arbiter bounds any single owner's tenure so that no engine starves another during Q-table updates.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- WORD_WIDTH, 16, memory address and data width.
- MAX_BURST, 8, maximum consecutive grant cycles while another requester is waiting; legal range 1..255.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- nrst  in  1  reset; synchronous, active-low.
- req  in  NREQ  request, one bit per requester; held high for the whole access burst.
- req_addr  in  NREQ*WORD_WIDTH  packed addresses; requester i uses bits [i*WORD_WIDTH +: WORD_WIDTH].
- req_wr_en  in  NREQ  per-requester write enable.
- req_wdata  in  NREQ*WORD_WIDTH  packed write data, same packing as req_addr.
- gnt  out  NREQ  one-hot grant, registered.
- rvalid  out  NREQ  read-data-valid, one bit per requester, registered.
- rdata  out  WORD_WIDTH  memory read data, broadcast to all requesters.
- mem_addr  out  WORD_WIDTH  memory address.
- mem_wr_en  out  1  memory write enable.
- mem_wdata  out  WORD_WIDTH  memory write data.
- mem_rdata  in  WORD_WIDTH  memory read data; synchronous memory, valid one cycle after the address.
- busy  out  1  high whenever any gnt bit is set.

Behaviour:
- Reset (nrst=0 at an edge): gnt=0, rvalid=0, busy=0, burst counter=0, state=IDLE, last-owner pointer=NREQ-1 so requester 0 wins first. Reset aborts any burst in progress immediately; no write is issued in the cycle after reset.
- States:
  - IDLE: no owner.
  - GRANT: owner index held in a register.
- IDLE -> GRANT: at an edge with any req bit high, pick a winner by round-robin, searching from last+1 mod NREQ upward with wrap. Set gnt to the winner's one-hot, set owner=winner and last=winner, clear the burst counter. Arbitration latency is 1 cycle from req to gnt.
- GRANT, hold: the owner keeps the grant while req[owner]=1 and either the burst counter < MAX_BURST-1 or no other req bit is set. The counter increments each held cycle and saturates at MAX_BURST-1.
- GRANT, rotate: at an edge where req[owner]=0, or where the counter = MAX_BURST-1 and another requester is pending:
  - Rerun round-robin from owner+1, excluding the owner when forced off.
  - If a winner exists, hand over directly (GRANT -> GRANT, no idle bubble) and clear the counter.
  - Otherwise go to IDLE with gnt=0.
- Datapath mux (combinational):
  - When gnt[i]=1 and req[i]=1: mem_addr, mem_wr_en and mem_wdata come from requester i.
  - Otherwise: mem_wr_en=0, mem_addr=0, mem_wdata=0.
  - A requester that drops req while still granted therefore never produces a stray write.
- Read return:
  - rvalid[i] is registered and equals (gnt[i] & req[i] & ~req_wr_en[i]) from the previous cycle; rdata=mem_rdata passthrough.
  - rvalid still fires for a read issued in the last owned cycle, even if gnt has already moved on.
  - rvalid is cleared by reset.
- Simultaneous events:
  - Multiple new requests in the same cycle: only round-robin order decides the winner.
  - The owner drops req in the same cycle a forced rotation would occur: treat as a release; the result is identical.
- A requester whose req drops and rises again while another requester is waiting goes behind that requester in round-robin order.
- MAX_BURST=1 gives pure per-cycle round-robin under contention.
- busy = |gnt.

Test Plan:
- Reset, then req=4'b0001 with addr0=16'h148, wr_en0=1, wdata0=16'h0005 held for 2 cycles -> gnt=0001 one cycle after req; mem_wr_en=1, mem_addr=16'h148 for 2 cycles; after req drops, gnt=0 the next cycle and mem_wr_en is never high after req falls.
- req=4'b1111 asserted together from reset, each held indefinitely, MAX_BURST=8 -> grant order 0,1,2,3,0 with exactly 8 cycles per owner and no idle cycle between owners.
- Owner 0 reading addr 16'h1C8 (mem returns 16'h0003), req1 waiting -> rvalid[0]=1 and rdata=16'h0003 one cycle after each read address; the last read before handover still produces rvalid[0].
- Requester 2 bursts alone for 20 cycles, MAX_BURST=8 -> gnt stays 0100 throughout with no forced rotation; req0 rises at cycle 12 -> gnt moves to 0001 within 1 cycle, since the counter is saturated.
- nrst pulled low mid-burst while owner 1 is writing -> the next cycle shows gnt=0, rvalid=0, mem_wr_en=0, busy=0; after release with req=4'b0011, requester 0 is granted first.
- req1 dropped and re-raised while req3 is pending -> gnt sequence is 1, 3, 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port synchronous data
// memory among NREQ requesters, with each owner's tenure bounded while others wait.
//
// Ports:
//   clock      : system clock, rising edge
//   nrst       : synchronous active-low reset
//   req        : per-requester request, held for the whole burst
//   req_addr   : packed addresses, requester i at [i*WORD_WIDTH +: WORD_WIDTH]
//   req_wr_en  : per-requester write enable
//   req_wdata  : packed write data, same packing as req_addr
//   gnt        : registered one-hot grant
//   rvalid     : registered per-requester read-data-valid
//   rdata      : memory read data broadcast to all requesters
//   mem_addr   : memory address
//   mem_wr_en  : memory write enable
//   mem_wdata  : memory write data
//   mem_rdata  : memory read data, valid one cycle after the address
//   busy       : high whenever any grant bit is set
module mem_arbiter #(
  parameter int NREQ       = 4,
  parameter int WORD_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                       clock,
  input  logic                       nrst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WORD_WIDTH-1:0] req_addr,
  input  logic [NREQ-1:0]            req_wr_en,
  input  logic [NREQ*WORD_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [WORD_WIDTH-1:0]      rdata,
  output logic [WORD_WIDTH-1:0]      mem_addr,
  output logic                       mem_wr_en,
  output logic [WORD_WIDTH-1:0]      mem_wdata,
  input  logic [WORD_WIDTH-1:0]      mem_rdata,
  output logic                       busy
);

  localparam int IDXW = $clog2(NREQ);
  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  // owner_q also serves as the last-owner pointer: it keeps its value in IDLE,
  // so the next search always starts just after whoever owned the port last.
  logic [IDXW-1:0] owner_q, owner_d;
  logic [7:0]      burstCnt_q, burstCnt_d;

  logic [NREQ-1:0] ownerMask;
  logic [NREQ-1:0] others;
  logic [NREQ-1:0] candidates;
  logic [IDXW-1:0] winIdx;
  logic            winFound;
  logic            holdGrant;

  // While granted, the owner itself is never a candidate: on release its req is
  // already low, and on a forced rotation it must be skipped.
  always_comb begin
    ownerMask          = '0;
    ownerMask[owner_q] = 1'b1;
    others             = req & ~ownerMask;
    candidates         = (state_q == GRANT) ? others : req;
  end

  // Round-robin search starting one past the last owner, wrapping around.
  always_comb begin
    int            idx;
    logic [IDXW-1:0] idxSel;
    idx      = 0;
    idxSel   = '0;
    winFound = 1'b0;
    winIdx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx    = (int'(owner_q) + k) % NREQ;
      idxSel = IDXW'(idx);
      if (!winFound && candidates[idxSel]) begin
        winFound = 1'b1;
        winIdx   = idxSel;
      end
    end
  end

  // Grant FSM next-state: hold while the owner still wants the port and either
  // has tenure left or nobody else is waiting; otherwise hand over or go idle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    burstCnt_d = burstCnt_q;
    holdGrant  = req[owner_q] && ((burstCnt_q < CNT_MAX) || (others == '0));
    rvalid_d   = gnt_q & req & ~req_wr_en;

    case (state_q)
      IDLE: begin
        if (winFound) begin
          state_d        = GRANT;
          gnt_d          = '0;
          gnt_d[winIdx]  = 1'b1;
          owner_d        = winIdx;
          burstCnt_d     = '0;
        end
      end
      GRANT: begin
        if (holdGrant) begin
          if (burstCnt_q < CNT_MAX) begin
            burstCnt_d = burstCnt_q + 8'd1;
          end
        end else if (winFound) begin
          gnt_d         = '0;
          gnt_d[winIdx] = 1'b1;
          owner_d       = winIdx;
          burstCnt_d    = '0;
        end else begin
          state_d    = IDLE;
          gnt_d      = '0;
          burstCnt_d = '0;
        end
      end
    endcase
  end

  // State register; reset abandons any burst and points "last" at NREQ-1 so
  // requester 0 is first in line.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      owner_q    <= IDXW'(NREQ - 1);
      burstCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      owner_q    <= owner_d;
      burstCnt_q <= burstCnt_d;
    end
  end

  // Port mux: a granted requester that has already dropped req drives nothing,
  // so it can never issue a stray write.
  always_comb begin
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i] && req[i]) begin
        mem_addr  = req_addr[i*WORD_WIDTH +: WORD_WIDTH];
        mem_wr_en = req_wr_en[i];
        mem_wdata = req_wdata[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign busy   = |gnt_q;
  assign rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a directed vector
// table, hand-written multi-cycle sequences and randomized traffic checked
// against a tenure-based round-robin reference model.
module tb_mem_arbiter;

  localparam int NREQ = 4;
  localparam int WW   = 16;
  localparam int MB   = 8;

  logic            clock;
  logic            nrst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] reqWr;
  logic [WW-1:0]   addrArr  [NREQ];
  logic [WW-1:0]   wdataArr [NREQ];
  logic [NREQ*WW-1:0] reqAddrPacked;
  logic [NREQ*WW-1:0] reqWdataPacked;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rvalid;
  logic [WW-1:0]   rdata;
  logic [WW-1:0]   memAddr;
  logic            memWrEn;
  logic [WW-1:0]   memWdata;
  logic [WW-1:0]   memRdata;
  logic            busy;

  int testsRun;
  int testsFailed;

  // Reference model state: owner index (-1 when idle), last owner, and how many
  // consecutive cycles the current owner has held the port.
  int            mOwner;
  int            mLast;
  int            mTenure;
  logic [NREQ-1:0] mRvalid;
  logic [WW-1:0]   mPrevAddr;

  typedef struct {
    logic            nrst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] wr;
    logic [NREQ-1:0] expGnt;
    logic            expWr;
    logic [WW-1:0]   expAddr;
    logic [NREQ-1:0] expRvalid;
  } vec_t;

  vec_t vecs [14];

  mem_arbiter #(.NREQ(NREQ), .WORD_WIDTH(WW), .MAX_BURST(MB)) dut (
    .clock     (clock),
    .nrst      (nrst),
    .req       (req),
    .req_addr  (reqAddrPacked),
    .req_wr_en (reqWr),
    .req_wdata (reqWdataPacked),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (memAddr),
    .mem_wr_en (memWrEn),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pack the per-requester address/data arrays onto the DUT buses.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      reqAddrPacked[i*WW +: WW]  = addrArr[i];
      reqWdataPacked[i*WW +: WW] = wdataArr[i];
    end
  end

  // Synchronous memory stand-in: read data is a fixed function of the address.
  function automatic logic [WW-1:0] memFunc(logic [WW-1:0] a);
    return (a == 16'h01C8) ? 16'h0003 : (a ^ 16'hA5A5);
  endfunction

  always @(posedge clock) memRdata <= memFunc(memAddr);

  function automatic logic [NREQ-1:0] ownerOneHot();
    return (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
  endfunction

  function automatic logic expSel();
    return (ownerOneHot() & req) != '0;
  endfunction

  function automatic int rrPick(logic [NREQ-1:0] cand, int from);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (from + k) % NREQ;
      if (cand[idx]) return idx;
    end
    return -1;
  endfunction

  // Advance the reference model by one rising edge using the applied inputs.
  task automatic modelStep();
    logic [NREQ-1:0] othersV;
    int w;
    mPrevAddr = expSel() ? addrArr[mOwner] : '0;
    if (!nrst) begin
      mOwner  = -1;
      mLast   = NREQ - 1;
      mTenure = 0;
      mRvalid = '0;
    end else begin
      mRvalid = ownerOneHot() & req & ~reqWr;
      if (mOwner < 0) begin
        w = rrPick(req, mLast);
        if (w >= 0) begin
          mOwner  = w;
          mLast   = w;
          mTenure = 1;
        end
      end else begin
        othersV = req & ~ownerOneHot();
        if (req[mOwner] && !(mTenure >= MB && othersV != '0)) begin
          mTenure++;
        end else begin
          w = rrPick(othersV, mOwner);
          if (w >= 0) begin
            mOwner  = w;
            mLast   = w;
            mTenure = 1;
          end else begin
            mOwner  = -1;
            mTenure = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    @(negedge clock);
  endtask

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(logic nrstV, logic [NREQ-1:0] reqV, logic [NREQ-1:0] wrV);
    nrst  = nrstV;
    req   = reqV;
    reqWr = wrV;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, '0);
    tick();
  endtask

  // Compare every DUT output with the reference model's view of this cycle.
  task automatic checkOutput(string label);
    int o;
    o = (mOwner >= 0) ? mOwner : 0;
    checkVal({label, " gnt"},       gnt,      ownerOneHot());
    checkVal({label, " busy"},      busy,     mOwner >= 0);
    checkVal({label, " rvalid"},    rvalid,   mRvalid);
    checkVal({label, " mem_wr_en"}, memWrEn,  expSel() ? reqWr[o] : 1'b0);
    checkVal({label, " mem_addr"},  memAddr,  expSel() ? addrArr[o] : '0);
    checkVal({label, " mem_wdata"}, memWdata, expSel() ? wdataArr[o] : '0);
    checkVal({label, " rdata"},     rdata,    memFunc(mPrevAddr));
  endtask

  initial begin
    logic [NREQ-1:0] reqV;
    logic [NREQ-1:0] expG;
    testsRun    = 0;
    testsFailed = 0;
    mOwner      = -1;
    mLast       = NREQ - 1;
    mTenure     = 0;
    mRvalid     = '0;
    mPrevAddr   = '0;
    addrArr     = '{16'h0148, 16'h0200, 16'h0300, 16'h0400};
    wdataArr    = '{16'h0005, 16'h0011, 16'h0022, 16'h0033};
    applyStimulus(1'b0, '0, '0);

    //                nrst  req      wr       gnt      wr    addr      rvalid
    vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000};
    vecs[1]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b1, 16'h0148, 4'b0000};
    vecs[2]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b1, 16'h0148, 4'b0000};
    vecs[3]  = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b0, 16'h0000, 4'b0000};
    vecs[4]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0, 16'h0200, 4'b0000};
    vecs[5]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0, 16'h0200, 4'b0010};
    vecs[6]  = '{1'b1, 4'b0110, 4'b0100, 4'b0010, 1'b0, 16'h0200, 4'b0010};
    vecs[7]  = '{1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 16'h0300, 4'b0000};
    vecs[8]  = '{1'b1, 4'b1101, 4'b0100, 4'b0100, 1'b1, 16'h0300, 4'b0000};
    vecs[9]  = '{1'b1, 4'b1001, 4'b0000, 4'b1000, 1'b0, 16'h0400, 4'b0000};
    vecs[10] = '{1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000};
    vecs[11] = '{1'b1, 4'b1001, 4'b0000, 4'b0001, 1'b0, 16'h0148, 4'b0000};
    vecs[12] = '{1'b1, 4'b1001, 4'b0000, 4'b0001, 1'b0, 16'h0148, 4'b0001};
    vecs[13] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].nrst, vecs[i].req, vecs[i].wr);
      tick();
      checkVal($sformatf("vec%0d gnt", i),       gnt,     vecs[i].expGnt);
      checkVal($sformatf("vec%0d busy", i),      busy,    vecs[i].expGnt != '0);
      checkVal($sformatf("vec%0d mem_wr_en", i), memWrEn, vecs[i].expWr);
      checkVal($sformatf("vec%0d mem_addr", i),  memAddr, vecs[i].expAddr);
      checkVal($sformatf("vec%0d rvalid", i),    rvalid,  vecs[i].expRvalid);
    end

    // Dropping req while still granted must kill the write immediately.
    doReset();
    applyStimulus(1'b1, 4'b0001, 4'b0001);
    tick();
    tick();
    checkVal("drop wr before", memWrEn, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0001);
    #1;
    checkVal("drop wr during", memWrEn, 1'b0);
    checkVal("drop gnt during", gnt, 4'b0001);
    tick();
    checkVal("drop gnt after", gnt, 4'b0000);

    // All four requesting continuously: 8 cycles each, in order, no gaps.
    doReset();
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    for (int k = 0; k < 33; k++) begin
      tick();
      expG = 4'b0001 << ((k / MB) % NREQ);
      checkVal($sformatf("rr cycle%0d gnt", k), gnt, expG);
      checkVal($sformatf("rr cycle%0d busy", k), busy, 1'b1);
    end

    // Owner 0 reading under contention; last read still returns rvalid.
    doReset();
    addrArr[0] = 16'h01C8;
    applyStimulus(1'b1, 4'b0011, 4'b0000);
    tick();
    checkVal("read gnt0", gnt, 4'b0001);
    for (int j = 1; j <= MB; j++) begin
      tick();
      checkVal($sformatf("read%0d rvalid", j), rvalid, 4'b0001);
      checkVal($sformatf("read%0d rdata", j), rdata, 16'h0003);
      checkVal($sformatf("read%0d gnt", j), gnt, (j < MB) ? 4'b0001 : 4'b0010);
    end
    tick();
    checkVal("read handover rvalid", rvalid, 4'b0010);
    checkVal("read handover rdata", rdata, 16'hA7A5);
    addrArr[0] = 16'h0148;

    // Lone long burst, then a late arrival takes over at once.
    doReset();
    applyStimulus(1'b1, 4'b0100, 4'b0100);
    for (int k = 0; k < 12; k++) begin
      tick();
      checkVal($sformatf("solo%0d gnt", k), gnt, 4'b0100);
    end
    applyStimulus(1'b1, 4'b0101, 4'b0100);
    tick();
    checkVal("solo takeover gnt", gnt, 4'b0001);

    // Reset mid-burst while requester 1 writes.
    doReset();
    applyStimulus(1'b1, 4'b0010, 4'b0010);
    tick();
    tick();
    tick();
    checkVal("midrst pre gnt", gnt, 4'b0010);
    applyStimulus(1'b0, 4'b0010, 4'b0010);
    tick();
    checkVal("midrst gnt", gnt, 4'b0000);
    checkVal("midrst rvalid", rvalid, 4'b0000);
    checkVal("midrst mem_wr_en", memWrEn, 1'b0);
    checkVal("midrst busy", busy, 1'b0);
    applyStimulus(1'b1, 4'b0011, 4'b0000);
    tick();
    checkVal("midrst regrant", gnt, 4'b0001);

    // Requester 1 re-raising goes behind the already-waiting requester 3.
    doReset();
    applyStimulus(1'b1, 4'b0010, 4'b0000);
    tick();
    checkVal("requeue gnt a", gnt, 4'b0010);
    applyStimulus(1'b1, 4'b1010, 4'b0000);
    tick();
    checkVal("requeue gnt b", gnt, 4'b0010);
    applyStimulus(1'b1, 4'b1000, 4'b0000);
    tick();
    checkVal("requeue gnt c", gnt, 4'b1000);
    applyStimulus(1'b1, 4'b1010, 4'b0000);
    tick();
    checkVal("requeue gnt d", gnt, 4'b1000);
    applyStimulus(1'b1, 4'b0010, 4'b0000);
    tick();
    checkVal("requeue gnt e", gnt, 4'b0010);

    // Randomized traffic with sticky requests so bursts and forced rotations occur.
    doReset();
    reqV = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 5) == 0) reqV[i] = ~reqV[i];
        addrArr[i]  = WW'($urandom);
        wdataArr[i] = WW'($urandom);
      end
      applyStimulus($urandom_range(0, 59) != 0, reqV, NREQ'($urandom));
      tick();
      checkOutput($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
